// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and pending-write lookup signals
// shared between the writeback arbiter and its environment.
interface regfile_wb_arbiter_if;
    logic        src0_val;
    logic        src0_rdy;
    logic [4:0]  src0_addr;
    logic [31:0] src0_data;
    logic        src1_val;
    logic        src1_rdy;
    logic [4:0]  src1_addr;
    logic [31:0] src1_data;
    logic        wr_stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic        full;
    logic        empty;

    modport master (
        output src0_val, src0_addr, src0_data,
        output src1_val, src1_addr, src1_data,
        output wr_stall, lk_addr,
        input  src0_rdy, src1_rdy, wr_en, wr_addr, wr_data,
        input  lk_hit, lk_data, full, empty
    );

    modport slave (
        input  src0_val, src0_addr, src0_data,
        input  src1_val, src1_addr, src1_data,
        input  wr_stall, lk_addr,
        output src0_rdy, src1_rdy, wr_en, wr_addr, wr_data,
        output lk_hit, lk_data, full, empty
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin writeback arbiter feeding an in-order write queue that
// drains into the register file's single write port, with a pending-write lookup.
module regfile_wb_arbiter #(
    parameter int p_num_entries = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int c_addr_nbits = $clog2(p_num_entries);
    localparam logic [c_addr_nbits:0] c_full_count = (c_addr_nbits+1)'(p_num_entries);

    logic [4:0]              r_addr [p_num_entries];
    logic [31:0]             r_data [p_num_entries];
    logic [c_addr_nbits-1:0] r_head;
    logic [c_addr_nbits-1:0] r_tail;
    logic [c_addr_nbits:0]   r_count;
    logic                    r_prio;

    logic        w_empty;
    logic        w_full;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;
    logic [4:0]  w_gnt_addr;
    logic [31:0] w_gnt_data;
    logic        w_enq;
    logic        w_deq;

    // Status is forced to the idle view while reset is held, since the
    // synchronous reset has not yet cleared the count.
    assign w_empty = reset || (r_count == '0);
    assign w_full  = !reset && (r_count == c_full_count);

    assign w_gnt0 = !reset && !w_full && bus.src0_val && (!bus.src1_val || !r_prio);
    assign w_gnt1 = !reset && !w_full && bus.src1_val && (!bus.src0_val ||  r_prio);
    assign w_gnt  = w_gnt0 || w_gnt1;

    assign w_gnt_addr = w_gnt0 ? bus.src0_addr : bus.src1_addr;
    assign w_gnt_data = w_gnt0 ? bus.src0_data : bus.src1_data;

    // Writes to the zero register are acknowledged but never queued.
    assign w_enq = w_gnt && (w_gnt_addr != 5'd0);
    assign w_deq = !w_empty && !bus.wr_stall;

    assign bus.src0_rdy = w_gnt0;
    assign bus.src1_rdy = w_gnt1;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.wr_en    = w_deq;
    assign bus.wr_addr  = w_empty ? 5'd0  : r_addr[r_head];
    assign bus.wr_data  = w_empty ? 32'd0 : r_data[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_prio  <= 1'b0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            if (w_enq && !w_deq)
                r_count <= r_count + 1'b1;
            else if (!w_enq && w_deq)
                r_count <= r_count - 1'b1;
            if (w_gnt) r_prio <= w_gnt0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= w_gnt_addr;
            r_data[r_tail] <= w_gnt_data;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [c_addr_nbits-1:0] w_idx;
        bus.lk_hit  = 1'b0;
        bus.lk_data = 32'd0;
        w_idx       = '0;
        for (int i = 0; i < p_num_entries; i++) begin
            w_idx = r_head + c_addr_nbits'(i);
            if (((c_addr_nbits+1)'(i) < r_count) && (r_addr[w_idx] == bus.lk_addr)) begin
                bus.lk_hit  = 1'b1;
                bus.lk_data = r_data[w_idx];
            end
        end
        if (reset || (bus.lk_addr == 5'd0)) begin
            bus.lk_hit  = 1'b0;
            bus.lk_data = 32'd0;
        end
    end
endmodule
